// File: rtl/gol_pkg.sv
// Shared definitions for the generation step controller: FSM state
// encoding and default widths for the period and generation counter.
package gol_pkg;

  localparam int PERIOD_W_DEF = 10;
  localparam int GEN_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

endpackage

// File: rtl/gen_step_ctrl_if.sv
// Control/handshake bundle between the timing source, the user controls,
// the life engine and the step controller.
// master: the step controller; slave: the surrounding system.
interface gen_step_ctrl_if #(
  parameter int PERIOD_W = gol_pkg::PERIOD_W_DEF,
  parameter int GEN_W    = gol_pkg::GEN_W_DEF
) ();

  logic                tick_in;
  logic                run_en;
  logic                step_btn;
  logic [PERIOD_W-1:0] period;
  logic                step_req;
  logic                step_ack;
  logic                busy;
  logic [GEN_W-1:0]    gen_count;

  modport master (
    input  tick_in, run_en, step_btn, period, step_ack,
    output step_req, busy, gen_count
  );

  modport slave (
    output tick_in, run_en, step_btn, period, step_ack,
    input  step_req, busy, gen_count
  );

endinterface

// File: rtl/gen_step_ctrl_edge_det.sv
// Single-flop edge detector. ANY_EDGE=1 pulses on either transition of d,
// ANY_EDGE=0 pulses on rising transitions only. The pulse is combinational
// and lasts the one clk cycle in which d differs from its delayed copy.
module edge_det #(
  parameter bit ANY_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic q;

  // Delay d by one clk so the current and previous levels can be compared.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign pulse = ANY_EDGE ? (d ^ q) : (d & ~q);

endmodule

// File: rtl/gen_step_ctrl.sv
// Generation step controller for the life engine. Converts millisecond
// tick toggles into periodic step requests while running, or issues a
// single step per button press while stopped, and tracks completed
// generations.
// Optional feature: define GEN_STEP_COUNT_EN to build the gen_count
// register; otherwise gen_count is tied to zero.
module gen_step_ctrl
  import gol_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int GEN_W    = GEN_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  gen_step_ctrl_if.master  bus
);

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;
  logic                step_req_q;
  logic                busy_q;
  logic                ms_evt;
  logic                step_evt;
  logic                handshake_done;

  // Every tick_in transition is one millisecond.
  edge_det #(.ANY_EDGE(1'b1)) u_tick_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.tick_in),
    .pulse (ms_evt)
  );

  // A press of the step button is its rising edge.
  edge_det #(.ANY_EDGE(1'b0)) u_step_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.step_btn),
    .pulse (step_evt)
  );

  // A period of zero behaves as one ms per generation.
  assign reload = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

  assign handshake_done = (state == REQ) && bus.step_ack;

  // Step sequencer: outputs are registered alongside the state so step_req
  // and busy change exactly on the edge that enters or leaves a state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      step_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (step_evt) begin
            state      <= REQ;
            step_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (bus.run_en) begin
            state  <= COUNT;
            cnt    <= reload;
            busy_q <= 1'b1;
          end
        end
        COUNT: begin
          // Stopping wins over a coincident ms event; step presses are
          // ignored while free-running.
          if (!bus.run_en) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (ms_evt) begin
            if (cnt <= PERIOD_W'(1)) begin
              state      <= REQ;
              step_req_q <= 1'b1;
            end else begin
              cnt <= cnt - PERIOD_W'(1);
            end
          end
        end
        REQ: begin
          // ms and step events arriving here are dropped, not queued.
          if (bus.step_ack) begin
            step_req_q <= 1'b0;
            if (bus.run_en) begin
              state <= COUNT;
              cnt   <= reload;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          step_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step_req = step_req_q;
  assign bus.busy     = busy_q;

`ifdef GEN_STEP_COUNT_EN
  logic [GEN_W-1:0] gen_q;

  // Completed generations; wraps silently at the top of the range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gen_q <= '0;
    else if (handshake_done) gen_q <= gen_q + GEN_W'(1);
  end

  assign bus.gen_count = gen_q;
`else
  logic unused_done;
  assign unused_done   = handshake_done;
  assign bus.gen_count = {GEN_W{1'b0}};
`endif

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Self-checking bench for gen_step_ctrl: a hand-derived vector table,
// directed multi-cycle sequences and randomized stimulus against an
// event-level reference model.
module tb_gen_step_ctrl;

  localparam int PW = 10;
  localparam int GW = 16;
`ifdef GEN_STEP_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gen_step_ctrl_if #(.PERIOD_W(PW), .GEN_W(GW)) bus ();

  gen_step_ctrl #(.PERIOD_W(PW), .GEN_W(GW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: is a step request outstanding, is the controller
  // timing a generation, how many ms remain, how many generations done.
  bit            m_pending;
  bit            m_timing;
  int            m_left;
  logic [GW-1:0] m_gens;
  bit            m_prev_tick;
  bit            m_prev_btn;

  function automatic int period_ms(input logic [PW-1:0] p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  task automatic model_reset();
    m_pending   = 1'b0;
    m_timing    = 1'b0;
    m_left      = 0;
    m_gens      = '0;
    m_prev_tick = 1'b0;
    m_prev_btn  = 1'b0;
  endtask

  task automatic model_edge();
    bit ms;
    bit press;
    ms    = (bus.tick_in != m_prev_tick);
    press = bus.step_btn && !m_prev_btn;
    if (m_pending) begin
      if (bus.step_ack) begin
        m_pending = 1'b0;
        m_gens    = m_gens + 1'b1;
        m_timing  = bus.run_en;
        m_left    = period_ms(bus.period);
      end
    end else if (m_timing) begin
      if (!bus.run_en) m_timing = 1'b0;
      else if (ms) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          m_timing  = 1'b0;
          m_pending = 1'b1;
        end
      end
    end else if (press) begin
      m_pending = 1'b1;
    end else if (bus.run_en) begin
      m_timing = 1'b1;
      m_left   = period_ms(bus.period);
    end
    m_prev_tick = bus.tick_in;
    m_prev_btn  = bus.step_btn;
  endtask

  function automatic logic [GW-1:0] exp_gen(input logic [GW-1:0] g);
    return COUNT_EN ? g : '0;
  endfunction

  task automatic apply(input bit run, input bit btn, input bit tick,
                       input int per, input bit ack);
    bus.run_en   = run;
    bus.step_btn = btn;
    bus.tick_in  = tick;
    bus.period   = PW'(per);
    bus.step_ack = ack;
  endtask

  // One clock: model follows the edge, outputs are sampled at the negedge.
  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_step_req"}, 32'(bus.step_req), 32'(m_pending));
    check({tag, "_busy"}, 32'(bus.busy), 32'(m_pending || m_timing));
    check({tag, "_gen_count"}, 32'(bus.gen_count), 32'(exp_gen(m_gens)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check("reset_step_req", 32'(bus.step_req), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_gen_count", 32'(bus.gen_count), 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit run;
    bit btn;
    bit tick;
    int per;
    bit ack;
    bit req;
    bit busy;
    int gen;
  } vec_t;

  vec_t vecs[11];

  int  rises;
  int  ack_hold;
  bit  prev_req;
  bit  cur_tick;
  bit  cur_btn;
  bit  cur_run;
  int  cur_per;

  task automatic count_rise();
    if (bus.step_req && !prev_req) rises++;
    prev_req = bus.step_req;
  endtask

  initial begin
    //         run btn tick per ack  req busy gen
    vecs[0]  = '{0, 0, 0, 3, 0, 0, 0, 0};  // idle, nothing happens
    vecs[1]  = '{0, 1, 0, 3, 0, 1, 1, 0};  // button press -> request
    vecs[2]  = '{0, 1, 1, 3, 0, 1, 1, 0};  // ms event ignored while requesting
    vecs[3]  = '{0, 0, 1, 3, 1, 0, 0, 1};  // ack, stopped -> idle
    vecs[4]  = '{1, 0, 1, 3, 0, 0, 1, 1};  // start running, load 3
    vecs[5]  = '{1, 0, 0, 3, 0, 0, 1, 1};  // ms 1
    vecs[6]  = '{1, 0, 1, 3, 0, 0, 1, 1};  // ms 2
    vecs[7]  = '{1, 1, 1, 3, 0, 0, 1, 1};  // press ignored while counting
    vecs[8]  = '{1, 1, 0, 3, 0, 1, 1, 1};  // ms 3 -> request
    vecs[9]  = '{1, 0, 0, 3, 1, 0, 1, 2};  // ack while running -> reload
    vecs[10] = '{0, 0, 0, 3, 0, 0, 0, 2};  // stop -> idle

    apply(0, 0, 0, 0, 0);
    do_reset();

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].run, vecs[i].btn, vecs[i].tick, vecs[i].per, vecs[i].ack);
      clk_cycle();
      check($sformatf("vec%0d_step_req", i), 32'(bus.step_req), 32'(vecs[i].req));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_gen_count", i), 32'(bus.gen_count),
            32'(exp_gen(GW'(vecs[i].gen))));
    end

    // Period 3, tick every 10 clk, ack two cycles after the request.
    do_reset();
    rises = 0; ack_hold = 0; prev_req = 1'b0; cur_tick = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c % 10 == 9) cur_tick = ~cur_tick;
      apply(1, 0, cur_tick, 3, ack_hold >= 2);
      clk_cycle();
      check_model("p3");
      count_rise();
      ack_hold = bus.step_req ? ack_hold + 1 : 0;
    end
    check("p3_rises", 32'(rises), 32'd2);
    check("p3_gens", 32'(bus.gen_count), 32'(exp_gen(GW'(2))));

    // Single step: button held 5 clk yields exactly one request.
    do_reset();
    rises = 0; prev_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      apply(0, 1, 0, 3, 0);
      clk_cycle();
      check_model("ss");
      count_rise();
    end
    apply(0, 0, 0, 3, 1);
    clk_cycle();
    check_model("ss_ack");
    count_rise();
    apply(0, 0, 0, 3, 0);
    clk_cycle();
    check("ss_rises", 32'(rises), 32'd1);
    check("ss_busy", 32'(bus.busy), 32'd0);
    check("ss_gens", 32'(bus.gen_count), 32'(exp_gen(GW'(1))));

    // Period 0: a request after every ms event, acked immediately.
    do_reset();
    rises = 0; prev_req = 1'b0; cur_tick = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cur_tick = ~cur_tick;
      apply(1, 0, cur_tick, 0, 1);
      clk_cycle();
      check_model("p0");
      count_rise();
    end
    check("p0_rises", 32'(rises), 32'd10);

    // Period 4, stopped after 2 ms, restarted needs a full 4 ms.
    do_reset();
    rises = 0; prev_req = 1'b0; cur_tick = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 2 || c == 4 || c == 10 || c == 12 || c == 14) cur_tick = ~cur_tick;
      apply(!(c == 6 || c == 7), 0, cur_tick, 4, 0);
      clk_cycle();
      check_model("stop");
      count_rise();
    end
    check("stop_no_req", 32'(rises), 32'd0);
    cur_tick = ~cur_tick;
    apply(1, 0, cur_tick, 4, 0);
    clk_cycle();
    check("stop_req_after_4", 32'(bus.step_req), 32'd1);
    check_model("stop_end");

    // Reset in the middle of a handshake.
    do_reset();
    for (int h = 0; h < 5; h++) begin
      apply(0, 1, 0, 2, 0);
      clk_cycle();
      apply(0, 0, 0, 2, 1);
      clk_cycle();
      apply(0, 0, 0, 2, 0);
      clk_cycle();
    end
    apply(0, 1, 0, 2, 0);
    clk_cycle();
    check_model("rst_pre");
    check("rst_pre_gens", 32'(bus.gen_count), 32'(exp_gen(GW'(5))));
    #2;
    rst_n = 1'b0;
    apply(0, 0, 1, 2, 0);
    model_reset();
    #1;
    check("rst_async_step_req", 32'(bus.step_req), 32'd0);
    check("rst_async_gen_count", 32'(bus.gen_count), 32'd0);
    check("rst_async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_cycle();
      check_model("rst_post");
    end

`ifdef GEN_STEP_COUNT_EN
    // Wrap of the generation counter from all ones to zero.
    do_reset();
    force dut.gen_q = '1;
    #1;
    release dut.gen_q;
    m_gens = '1;
    check("wrap_pre", 32'(bus.gen_count), 32'hFFFF);
    apply(0, 1, 0, 1, 0);
    clk_cycle();
    apply(0, 0, 0, 1, 1);
    clk_cycle();
    check("wrap_post", 32'(bus.gen_count), 32'h0000);
    check_model("wrap");
`endif

    // Randomized stimulus against the model.
    do_reset();
    cur_tick = 1'b0; cur_btn = 1'b0; cur_run = 1'b0; cur_per = 2;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) cur_tick = ~cur_tick;
      if ($urandom_range(0, 4) == 0) cur_btn = ~cur_btn;
      if ($urandom_range(0, 19) == 0) cur_run = ~cur_run;
      if ($urandom_range(0, 15) == 0) cur_per = int'($urandom_range(0, 5));
      apply(cur_run, cur_btn, cur_tick, cur_per, $urandom_range(0, 2) == 0);
      clk_cycle();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_step_ctrl.md
GEN_STEP_CTRL -- requirements
Module: gen_step_ctrl

Interface
REQ-001 Parameter: PERIOD_W, 10, width of the period input (ms events per generation).
REQ-002 Parameter: GEN_W, 16, width of the generation counter.
REQ-003 Port: clk  input  1  single system clock; all logic on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: tick_in  input  1  1 ms toggle from the millisecond timer, synchronous to clk; each transition (either direction) = one ms event.
REQ-006 Port: run_en  input  1  level; 1 = free-running generations.
REQ-007 Port: step_btn  input  1  debounced level; each rising edge requests one single step.
REQ-008 Port: period  input  PERIOD_W  ms events per generation; 0 treated as 1; sampled at reload only.
REQ-009 Port: step_req  output  1  registered; request to life engine to compute one generation.
REQ-010 Port: step_ack  input  1  engine acknowledge; ignored unless step_req=1.
REQ-011 Port: busy  output  1  registered; 1 whenever state != IDLE.
REQ-012 Port: gen_count  output  GEN_W  registered; completed generations.

Function
REQ-013 ms_evt SHALL be tick_in XOR tick_q (tick_q = tick_in delayed one clk); 1-cycle pulse per tick_in transition.
REQ-014 step_evt SHALL be step_btn AND NOT step_q (step_q = step_btn delayed one clk).
REQ-015 FSM states SHALL be IDLE, COUNT, REQ; step_req=1 only in REQ; busy=1 in COUNT and REQ.
REQ-016 IDLE: step_evt -> REQ (priority); else run_en=1 -> COUNT, cnt loaded with max(period,1); else stay.
REQ-017 COUNT: run_en=0 -> IDLE, cnt discarded (takes priority over ms_evt); else on ms_evt with cnt<=1 -> REQ; else on ms_evt cnt decrements by 1.
REQ-018 step_evt in COUNT SHALL be ignored.
REQ-019 step_req SHALL be high on the first clk edge after the cycle in which the expiring ms_evt is high (latency 1 clk from ms_evt).
REQ-020 REQ: step_req held high until step_ack=1 is sampled; on that edge step_req clears, gen_count increments, state -> COUNT with reload if run_en=1, else IDLE.
REQ-021 ms_evt and step_evt during REQ SHALL be ignored (no queuing, no accumulated debt).
REQ-022 step_ack already high on entry to REQ SHALL complete the handshake on the first REQ cycle (minimum step_req pulse 1 clk).
REQ-023 gen_count SHALL wrap from 2^GEN_W-1 to 0 without flag.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, step_req 0, busy 0, gen_count 0, cnt 0, tick_q 0, step_q 0.
REQ-025 Reset mid-handshake SHALL drop step_req without waiting for step_ack; the first ms_evt after release (tick_in=1) SHALL be harmless in IDLE.

Configuration
REQ-026 Macro GEN_STEP_COUNT_EN defined: gen_count register and increment per REQ-020/REQ-023 present.
REQ-027 Macro GEN_STEP_COUNT_EN undefined: gen_count SHALL be constant 0, no counter flops; all other behaviour unchanged.

Structure
REQ-028 Shared package gol_pkg SHALL hold the FSM state enum (IDLE/COUNT/REQ) and default PERIOD_W/GEN_W constants.
REQ-029 One sub-module edge_det (rising/any-edge detector, async active-low reset) SHALL be instantiated for tick_in (any edge) and step_btn (rising).

Verification
REQ-030 period=3, run_en=1, tick_in toggled every 10 clk -> step_req rises 1 clk after 3rd ms_evt; step_ack 2 clk later -> step_req 0, gen_count=1, next REQ after 3 more ms_evt.
REQ-031 run_en=0, step_btn high 5 clk -> exactly one step_req; ack -> state IDLE, busy 0, gen_count=1.
REQ-032 period=0, run_en=1 -> step_req after every single ms_evt (acked immediately each time).
REQ-033 run_en=1, period=4, drop run_en after 2 ms_evt -> IDLE, no step_req; re-assert -> full 4 ms_evt before step_req.
REQ-034 rst_n pulled low while step_req=1 and gen_count=5 -> step_req 0 and gen_count 0 without waiting for a clk edge.
REQ-035 gen_count=0xFFFF, one completed handshake -> gen_count=0x0000; with GEN_STEP_COUNT_EN undefined gen_count stays 0 throughout.
